// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-side valid/ready handshake into the UART transmit FIFO
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable width, parity and stop bits
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 2000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  uart_tx_fifo_if.slave               tx,
  output logic                        uart_txd,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BPS_CNT);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam logic [CW-1:0] LAST_CLK  = CW'(BPS_CNT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_count;

  state_t               r_state;
  logic [CW-1:0]        r_clk_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_par;

  // Ready comes only from the registered count, so a same-cycle pop never frees a full FIFO.
  assign w_full      = (r_count == FULL_LVL);
  assign w_push      = tx.tx_valid && !w_full;
  assign w_bit_end   = (r_clk_cnt == LAST_CLK);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);
  assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_frame_end);
  assign w_head      = r_mem[r_rptr];
  assign w_head_par  = (PARITY == 1) ? ~^w_head : ^w_head;

  assign tx.tx_ready = !w_full;
  assign uart_txd    = r_txd;
  assign busy        = r_busy;
  assign tx_done     = r_done;
  assign fifo_level  = r_count;

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wptr] <= tx.tx_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_START;
            r_txd   <= 1'b0;
            r_shift <= w_head;
            r_par   <= w_head_par;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              if (PARITY != 0) begin
                r_state <= S_PAR;
                r_txd   <= r_par;
              end else begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        S_PAR: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
              // Chain straight into the next start bit when more data is waiting.
              if (w_pop) begin
                r_state <= S_START;
                r_txd   <= 1'b0;
                r_shift <= w_head;
                r_par   <= w_head_par;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed checks of uart_tx_fifo across four parameter sets
module tb_uart_tx_fifo;
  logic       sys_clk;
  logic       sys_rst_n;
  logic [8:0] tb_data;
  logic       v    [4];
  logic       rdy  [4];
  logic       txd  [4];
  logic       bsy  [4];
  logic       done [4];
  logic [4:0] lvl  [4];

  int n_checks;
  int n_errors;

  typedef struct {
    int          s;
    logic [8:0]  d;
    logic [15:0] pat;
    int          nb;
  } vec_t;
  vec_t vecs [9];

  logic rec  [0:5399];
  logic rec2 [0:699];

  uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_data = tb_data[7:0];
  assign if1.tx_data = tb_data[6:0];
  assign if2.tx_data = tb_data[6:0];
  assign if3.tx_data = tb_data[7:0];
  assign if0.tx_valid = v[0];
  assign if1.tx_valid = v[1];
  assign if2.tx_valid = v[2];
  assign if3.tx_valid = v[3];
  assign rdy[0] = if0.tx_ready;
  assign rdy[1] = if1.tx_ready;
  assign rdy[2] = if2.tx_ready;
  assign rdy[3] = if3.tx_ready;

  uart_tx_fifo u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx(if0.slave),
    .uart_txd(txd[0]), .busy(bsy[0]), .tx_done(done[0]), .fifo_level(lvl[0])
  );
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx(if1.slave),
    .uart_txd(txd[1]), .busy(bsy[1]), .tx_done(done[1]), .fifo_level(lvl[1])
  );
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx(if2.slave),
    .uart_txd(txd[2]), .busy(bsy[2]), .tx_done(done[2]), .fifo_level(lvl[2])
  );
  uart_tx_fifo #(.STOP_BITS(2)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx(if3.slave),
    .uart_txd(txd[3]), .busy(bsy[3]), .tx_done(done[3]), .fifo_level(lvl[3])
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pushes one word at edge k, then checks every cycle of the frame on the line.
  task automatic frame_check(input int s, input logic [8:0] d, input logic [15:0] pat,
                             input int nb, input string nm);
    int bad [16];
    int bad_busy;
    int done_at;
    int done_cnt;
    int busy_after;
    for (int i = 0; i < 16; i++) bad[i] = 0;
    bad_busy = 0; done_at = -1; done_cnt = 0; busy_after = 1;
    @(negedge sys_clk);
    tb_data = d; v[s] = 1'b1;
    @(posedge sys_clk);
    #1;
    v[s] = 1'b0; tb_data = ~d;
    @(negedge sys_clk);
    chk({nm, "_level_after_push"}, int'(lvl[s]), 1);
    chk({nm, "_line_idle_at_k"}, int'(txd[s]), 1);
    for (int j = 1; j <= nb * 25 + 2; j++) begin
      @(negedge sys_clk);
      if (j <= nb * 25) begin
        if (txd[s] !== pat[(j - 1) / 25]) bad[(j - 1) / 25]++;
        if (bsy[s] !== 1'b1) bad_busy++;
      end
      if (j == nb * 25 + 1) busy_after = int'(bsy[s]);
      if (done[s] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
    end
    for (int i = 0; i < nb; i++) chk($sformatf("%s_slot%0d_bad_cycles", nm, i), bad[i], 0);
    chk({nm, "_busy_low_cycles"}, bad_busy, 0);
    chk({nm, "_done_cycle"}, done_at, nb * 25 + 1);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_busy_after"}, busy_after, 0);
  endtask

  initial begin
    int idx, t0, last_done, ndone, maxl, rdy_bad, full_seen, n, a, b, c, d;
    logic acc;
    logic [9:0] exp_w, got_w;

    n_checks = 0; n_errors = 0;
    tb_data = '0;
    for (int i = 0; i < 4; i++) v[i] = 1'b0;

    vecs[0] = '{0, 9'h0A5, 16'b1101001010, 10};
    vecs[1] = '{0, 9'h000, 16'b1000000000, 10};
    vecs[2] = '{0, 9'h0FF, 16'b1111111110, 10};
    vecs[3] = '{0, 9'h03C, 16'b1001111000, 10};
    vecs[4] = '{1, 9'h055, 16'b1010101010, 10};
    vecs[5] = '{1, 9'h001, 16'b1100000010, 10};
    vecs[6] = '{2, 9'h055, 16'b1110101010, 10};
    vecs[7] = '{3, 9'h0A5, 16'b11101001010, 11};
    vecs[8] = '{2, 9'h001, 16'b1000000010, 10};

    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_txd", int'(txd[0]), 1);
    chk("rst_ready", int'(rdy[0]), 1);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_level", int'(lvl[0]), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int k = 0; k < 9; k++)
      frame_check(vecs[k].s, vecs[k].d, vecs[k].pat, vecs[k].nb, $sformatf("vec%0d", k));

    // Burst of 20 bytes with valid held high.
    idx = 0; acc = 1'b0; t0 = -1; last_done = -1; ndone = 0; maxl = 0; rdy_bad = 0; full_seen = 0;
    for (int cy = 0; cy < 5400; cy++) begin
      @(negedge sys_clk);
      rec[cy] = txd[0];
      if (t0 < 0 && txd[0] == 1'b0) t0 = cy;
      if (done[0] == 1'b1) begin ndone++; last_done = cy; end
      if (int'(lvl[0]) > maxl) maxl = int'(lvl[0]);
      if (rdy[0] != (lvl[0] != 5'd16)) rdy_bad++;
      if (lvl[0] == 5'd16 && rdy[0] == 1'b0) full_seen++;
      if (acc) idx++;
      if (idx < 20) begin v[0] = 1'b1; tb_data = 9'(idx); end
      else v[0] = 1'b0;
      acc = v[0] && rdy[0];
    end
    v[0] = 1'b0;
    chk("burst_accepted", idx, 20);
    chk("burst_max_level", maxl, 16);
    chk("burst_ready_vs_level", rdy_bad, 0);
    chk("burst_full_not_ready_seen", int'(full_seen > 0), 1);
    chk("burst_done_count", ndone, 20);
    chk("burst_total_clocks", last_done - t0, 5000);
    if (t0 < 0) t0 = 0;
    for (int m = 0; m < 20; m++) begin
      exp_w = {1'b1, 8'(m), 1'b0};
      for (int i = 0; i < 10; i++) got_w[i] = rec[t0 + m * 250 + i * 25 + 12];
      chk($sformatf("burst_frame%0d", m), int'(got_w), int'(exp_w));
    end

    // Full FIFO: the pop edge must not admit a push.
    tb_data = 9'h077; v[0] = 1'b1;
    n = 0;
    while (lvl[0] != 5'd16 && n < 100) begin @(negedge sys_clk); n++; end
    chk("full_level", int'(lvl[0]), 16);
    chk("full_ready", int'(rdy[0]), 0);
    n = 0;
    while (lvl[0] == 5'd16 && n < 400) begin @(negedge sys_clk); n++; end
    chk("full_pop_refused_level", int'(lvl[0]), 15);
    chk("full_pop_ready", int'(rdy[0]), 1);
    @(negedge sys_clk);
    chk("full_refill_level", int'(lvl[0]), 16);
    chk("full_refill_ready", int'(rdy[0]), 0);
    v[0] = 1'b0;

    // Mid-frame reset with 5 bytes queued.
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    tb_data = 9'h000; v[0] = 1'b1;
    repeat (6) @(negedge sys_clk);
    v[0] = 1'b0;
    repeat (108) @(negedge sys_clk);
    chk("pre_rst_level", int'(lvl[0]), 5);
    chk("pre_rst_busy", int'(bsy[0]), 1);
    chk("pre_rst_line_bit3", int'(txd[0]), 0);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", int'(txd[0]), 1);
    chk("mid_rst_level", int'(lvl[0]), 0);
    chk("mid_rst_busy", int'(bsy[0]), 0);
    chk("mid_rst_ready", int'(rdy[0]), 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    n = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge sys_clk);
      if (txd[0] !== 1'b1 || bsy[0] !== 1'b0 || lvl[0] !== 5'd0) n++;
    end
    chk("post_rst_idle_bad_cycles", n, 0);
    frame_check(0, 9'h05A, 16'b1010110100, 10, "post_rst");

    // Two stop bits between back-to-back frames.
    @(negedge sys_clk);
    tb_data = 9'h000; v[3] = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    v[3] = 1'b0;
    for (int j = 0; j < 700; j++) begin
      @(negedge sys_clk);
      rec2[j] = txd[3];
    end
    a = 0;
    while (a < 699 && rec2[a] != 1'b0) a++;
    b = a;
    while (b < 699 && rec2[b] != 1'b1) b++;
    c = b;
    while (c < 699 && rec2[c] != 1'b0) c++;
    d = c;
    while (d < 699 && rec2[d] != 1'b1) d++;
    chk("stop2_first_low", b - a, 225);
    chk("stop2_high_gap", c - b, 50);
    chk("stop2_second_low", d - c, 225);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 2 Mbps sender.
- Adds configurable baud divider, data width, parity and stop bits.
- Adds an input FIFO with a valid/ready handshake, so a producer can burst bytes and frames go out back-to-back with no idle gap.
- Sits between any on-chip byte producer (debug/console/streaming logic) and the board TXD pin.

Parameters:
- CLK_FREQ, 50000000: sys_clk frequency in Hz.
- BAUD, 2000000: line rate; bit period BPS_CNT = CLK_FREQ/BAUD clocks, truncated integer, must be >= 2.
- DATA_BITS, 8: payload bits per frame, legal 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, power of 2, >= 2.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to queue.
- tx_valid  in  1  producer has data.
- tx_ready  out  1  FIFO can accept; equals !full, derived from registered count.
- uart_txd  out  1  serial line, registered.
- busy  out  1  FSM not IDLE.
- tx_done  out  1  one-cycle pulse at the end of each frame.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries queued, not counting the frame in flight.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - uart_txd=1, tx_ready=1, busy=0, tx_done=0, fifo_level=0.
  - FIFO emptied, FSM to IDLE, bit and clock counters cleared.
  - No partial frame resumes after release.
- Handshake:
  - Push occurs on a rising edge with tx_valid && tx_ready.
  - Level-sensitive, not edge-detected: holding tx_valid high pushes one entry per cycle while ready.
  - tx_data is don't-care when tx_valid=0.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push only: level+1. Pop only: level-1. Push and pop in the same cycle: level unchanged.
  - When full, tx_ready=0 for the whole cycle even if a pop happens that cycle; the push is refused and the producer retries.
  - No pop when empty.
  - Order strictly preserved.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: uart_txd=1. If FIFO non-empty on an edge: pop the head into a shift register, enter START, uart_txd<=0 on that same edge.
  - Latency: a push accepted at edge k into an empty FIFO with FSM IDLE gives uart_txd low from edge k+1.
  - Every state holds its line value for exactly BPS_CNT clocks; clk_cnt runs 0..BPS_CNT-1.
  - START -> DATA. DATA sends bit 0 first, DATA_BITS bits, then goes to PAR if PARITY != 0, else STOP.
  - PAR bit: odd = ~^data, even = ^data, computed on the popped word.
  - STOP: line high for STOP_BITS*BPS_CNT clocks.
  - At the end of STOP, tx_done pulses for 1 cycle. If the FIFO is non-empty, pop and enter START on that same edge (zero idle gap); else go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BPS_CNT clocks.
- busy=1 from the START entry edge through the final STOP cycle.
- Changing tx_data after acceptance never affects queued or in-flight frames.

Test Plan:
- Defaults (BPS_CNT=25), push 0xA5 at edge k:
  - uart_txd low edges k+1..k+25.
  - Then 1,0,1,0,0,1,0,1, 25 clocks each.
  - Stop high 25 clocks; frame 250 clocks.
  - tx_done single pulse 250 clocks after the fall; busy returns to 0.
- tx_valid held high with 20 bytes 0x00..0x13:
  - tx_ready drops when fifo_level=16.
  - All 20 bytes sent in order, back-to-back, 5000 clocks total with no high gap beyond stop bits.
  - fifo_level never exceeds 16.
- DATA_BITS=7, PARITY=2, send 0x55: parity bit 0; with PARITY=1, parity bit 1. Frame 10 bits = 250 clocks.
- STOP_BITS=2, two queued bytes: line high exactly 50 clocks between frames; next start bit follows immediately.
- FIFO full with a pop coinciding with tx_valid: push refused that cycle (tx_ready=0); accepted next cycle; level returns to 16.
- Assert sys_rst_n low mid data bit 3 with 5 bytes queued:
  - uart_txd=1 immediately, fifo_level=0, busy=0.
  - After release, line stays idle high until a new push.
